// File: rtl/wb_writeback_if.sv
// Write-back stage bus bundle: ALU result handshake, load descriptor
// handshake, memory read response and the register-file write port.
// slave  = write-back stage, master = the pipeline/memory side driving it.
interface wb_writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_data;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd_addr;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rd0_addr;
  logic        rd0_wr_en;
  logic [31:0] rd0_data;

  modport slave (
    input  alu_valid, alu_rd_addr, alu_data,
    input  ld_req_valid, ld_rd_addr, ld_funct3, ld_byte_off,
    input  mem_rsp_valid, mem_rsp_data,
    output alu_ready, ld_req_ready,
    output rd0_addr, rd0_wr_en, rd0_data
  );

  modport master (
    output alu_valid, alu_rd_addr, alu_data,
    output ld_req_valid, ld_rd_addr, ld_funct3, ld_byte_off,
    output mem_rsp_valid, mem_rsp_data,
    input  alu_ready, ld_req_ready,
    input  rd0_addr, rd0_wr_en, rd0_data
  );
endinterface

// File: rtl/wb_writeback.sv
// wb_writeback: register-file write-back stage.
// Merges single-cycle ALU results with in-order load responses (loads win),
// keeps a FIFO of outstanding load descriptors, applies RV32I load
// extension and suppresses writes to x0. Writes are registered (1 cycle).
// Optional feature: define WB_BYPASS_EN to add rs1/rs2 forwarding of the
// write currently presented to the register file.
module wb_writeback #(
  parameter  int LD_DEPTH = 4,
  localparam int CNT_W    = $clog2(LD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  wb_writeback_if.slave    bus,
  output logic [CNT_W-1:0] ld_count,
  output logic             ld_pending,
  output logic             proto_err
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_hit,
  output logic             rs2_hit,
  output logic [31:0]      rs1_fwd,
  output logic [31:0]      rs2_fwd
`endif
);

  localparam int PTR_W = $clog2(LD_DEPTH);

  // Descriptor FIFO storage and bookkeeping
  logic [4:0]       q_rd  [LD_DEPTH];
  logic [2:0]       q_f3  [LD_DEPTH];
  logic [1:0]       q_off [LD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        pop;
  logic        push;
  logic        alu_fire;
  logic [4:0]  head_rd;
  logic [2:0]  head_f3;
  logic [1:0]  head_off;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ld_val;
  logic        f3_ok;

  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;

  // A response only pops when something is queued; an empty-FIFO response is an error.
  assign pop          = clk_en & bus.mem_rsp_valid & (count != {CNT_W{1'b0}});
  assign bus.ld_req_ready = clk_en & ((count < CNT_W'(LD_DEPTH)) | pop);
  assign push         = bus.ld_req_valid & bus.ld_req_ready;
  assign bus.alu_ready = clk_en & ~bus.mem_rsp_valid;
  assign alu_fire     = bus.alu_valid & bus.alu_ready;

  assign head_rd  = q_rd[rd_ptr];
  assign head_f3  = q_f3[rd_ptr];
  assign head_off = q_off[rd_ptr];

  assign ld_count   = count;
  assign ld_pending = (count != {CNT_W{1'b0}});
  assign bus.rd0_wr_en = wr_en_q;
  assign bus.rd0_addr  = wr_addr_q;
  assign bus.rd0_data  = wr_data_q;

  // Lane select of the byte/half addressed by the load offset
  always_comb begin
    sel_b = bus.mem_rsp_data[7:0];
    sel_h = bus.mem_rsp_data[15:0];
    case (head_off)
      2'd0: begin sel_b = bus.mem_rsp_data[7:0];   sel_h = bus.mem_rsp_data[15:0]; end
      2'd1: begin sel_b = bus.mem_rsp_data[15:8];  sel_h = bus.mem_rsp_data[23:8]; end
      2'd2: begin sel_b = bus.mem_rsp_data[23:16]; sel_h = bus.mem_rsp_data[31:16]; end
      2'd3: begin sel_b = bus.mem_rsp_data[31:24]; sel_h = {8'h00, bus.mem_rsp_data[31:24]}; end
      default: begin sel_b = 8'h00; sel_h = 16'h0000; end
    endcase
  end

  // Sign/zero extension by load type; a half at offset 3 is only the top byte
  always_comb begin
    ld_val = 32'h0000_0000;
    f3_ok  = 1'b1;
    case (head_f3)
      3'b000: ld_val = {{24{sel_b[7]}}, sel_b};
      3'b001: begin
        if (head_off == 2'd3) begin
          ld_val = {{24{sel_b[7]}}, sel_b};
        end else begin
          ld_val = {{16{sel_h[15]}}, sel_h};
        end
      end
      3'b010: ld_val = bus.mem_rsp_data;
      3'b100: ld_val = {24'h00_0000, sel_b};
      3'b101: ld_val = {16'h0000, sel_h};
      default: begin
        ld_val = 32'h0000_0000;
        f3_ok  = 1'b0;
      end
    endcase
  end

  // Descriptor storage write; contents need no reset, occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]  <= bus.ld_rd_addr;
      q_f3[wr_ptr]  <= bus.ld_funct3;
      q_off[wr_ptr] <= bus.ld_byte_off;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port: load response first, else ALU beat; x0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'h0000_0000;
    end else if (clk_en) begin
      if (pop) begin
        if (f3_ok && (head_rd != 5'd0)) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= head_rd;
          wr_data_q <= ld_val;
        end else begin
          wr_en_q <= 1'b0;
        end
      end else if (alu_fire) begin
        if (bus.alu_rd_addr != 5'd0) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= bus.alu_rd_addr;
          wr_data_q <= bus.alu_data;
        end else begin
          wr_en_q <= 1'b0;
        end
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  // Sticky protocol error: orphan response or unsupported load type
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (clk_en && bus.mem_rsp_valid && ((count == {CNT_W{1'b0}}) || !f3_ok)) begin
      proto_err <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write the register file has not committed yet
  always_comb begin
    rs1_hit = wr_en_q & (wr_addr_q == rs1_addr) & (rs1_addr != 5'd0);
    rs2_hit = wr_en_q & (wr_addr_q == rs2_addr) & (rs2_addr != 5'd0);
    if (rs1_hit) rs1_fwd = wr_data_q;
    else         rs1_fwd = 32'h0000_0000;
    if (rs2_hit) rs2_fwd = wr_data_q;
    else         rs2_fwd = 32'h0000_0000;
  end
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: expected register-file writes are
// pushed to a scoreboard as stimulus is driven and popped by a monitor
// whenever rd0_wr_en is seen. Descriptor and error state are modelled here.
module tb_wb_writeback;
  localparam int LD_DEPTH = 4;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [4:0] rd; logic [2:0] f3; logic [1:0] off; } desc_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic [2:0] ld_count;
  logic ld_pending;
  logic proto_err;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_fwd, rs2_fwd;
`endif

  wb_writeback_if bus();

  wb_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus.slave),
    .ld_count(ld_count), .ld_pending(ld_pending), .proto_err(proto_err)
`ifdef WB_BYPASS_EN
    , .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err    = 0;
  wr_t   sb[$];
  desc_t mq[$];
  logic  m_perr;

  // Single comparison point: count it, report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference RV32I load extension
  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: begin b = w[7:0];   h = w[15:0];  end
      2'd1: begin b = w[15:8];  h = w[23:8];  end
      2'd2: begin b = w[23:16]; h = w[31:16]; end
      default: begin b = w[31:24]; h = {{8{w[31]}}, w[31:24]}; end
    endcase
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b010: return w;
      3'b100: return {24'h0, b};
      3'b101: return (off == 2'd3) ? {24'h0, b} : {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (bus.rd0_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'h0, bus.rd0_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("rd0_addr", {27'h0, bus.rd0_addr}, {27'h0, e.a});
        check("rd0_data", bus.rd0_data, e.d);
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_ld_count"}, {29'h0, ld_count}, 32'(mq.size()));
    check({tag, "_ld_pending"}, {31'h0, ld_pending}, {31'h0, (mq.size() != 0)});
    check({tag, "_proto_err"}, {31'h0, proto_err}, {31'h0, m_perr});
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd_addr = 5'd0; bus.alu_data = 32'h0;
    bus.ld_req_valid = 1'b0; bus.ld_rd_addr = 5'd0; bus.ld_funct3 = 3'd0; bus.ld_byte_off = 2'd0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'h0;
  endtask

  // One clock of stimulus; model and scoreboard updated from the bench's own view
  task automatic beat(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] lf3, input logic [1:0] loff,
                      input logic rv, input logic [31:0] rdat);
    desc_t h;
    bit    popping, can_push;
    bus.alu_valid = av; bus.alu_rd_addr = ard; bus.alu_data = ad;
    bus.ld_req_valid = lv; bus.ld_rd_addr = lrd; bus.ld_funct3 = lf3; bus.ld_byte_off = loff;
    bus.mem_rsp_valid = rv; bus.mem_rsp_data = rdat;
    #2;
    popping  = rv && (mq.size() > 0);
    can_push = (mq.size() < LD_DEPTH) || popping;
    check("alu_ready", {31'h0, bus.alu_ready}, {31'h0, !rv});
    check("ld_req_ready", {31'h0, bus.ld_req_ready}, {31'h0, can_push});
    if (rv) begin
      if (popping) begin
        h = mq.pop_front();
        if (h.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          if (h.rd != 5'd0) sb.push_back('{a: h.rd, d: ext_model(rdat, h.f3, h.off)});
        end else begin
          m_perr = 1'b1;
        end
      end else begin
        m_perr = 1'b1;
      end
    end else if (av && (ard != 5'd0)) begin
      sb.push_back('{a: ard, d: ad});
    end
    if (lv && can_push) mq.push_back('{rd: lrd, f3: lf3, off: loff});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic push_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    beat(1'b0, 5'd0, 32'h0, 1'b1, rd, f3, off, 1'b0, 32'h0);
  endtask

  task automatic rsp(input logic [31:0] d);
    beat(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, d);
  endtask

  task automatic nop();
    beat(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    sb.delete();
    m_perr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; m_perr = 1'b0;
    idle_inputs();
`ifdef WB_BYPASS_EN
    rs1_addr = 5'd0; rs2_addr = 5'd0;
`endif
    @(posedge clk); #1;
    do_reset();
    // Reset state
    check("rst_wr_en", {31'h0, bus.rd0_wr_en}, 32'h0);
    check("rst_addr", {27'h0, bus.rd0_addr}, 32'h0);
    check("rst_data", bus.rd0_data, 32'h0);
    check_state("rst");

    // ALU write, then the pulse must drop
    beat(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    check("alu_wr_en_hi", {31'h0, bus.rd0_wr_en}, 32'h1);
`ifdef WB_BYPASS_EN
    rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
    check("rs1_hit", {31'h0, rs1_hit}, 32'h1);
    check("rs1_fwd", rs1_fwd, 32'hDEAD_BEEF);
    check("rs2_hit", {31'h0, rs2_hit}, 32'h0);
    check("rs2_fwd", rs2_fwd, 32'h0);
`endif
    nop();
    check("alu_wr_en_lo", {31'h0, bus.rd0_wr_en}, 32'h0);

    // Load extension cases
    push_ld(5'd3, 3'b000, 2'd2); rsp(32'h1280_FF00);
    push_ld(5'd3, 3'b100, 2'd2); rsp(32'h1280_FF00);
    push_ld(5'd3, 3'b101, 2'd2); rsp(32'h1280_FF00);
    push_ld(5'd4, 3'b001, 2'd1); rsp(32'h00F0_0F00);
    push_ld(5'd4, 3'b001, 2'd3); rsp(32'h8000_0000);
    push_ld(5'd4, 3'b101, 2'd3); rsp(32'h8000_0000);
    push_ld(5'd8, 3'b010, 2'd3); rsp(32'hCAFE_F00D);
    check_state("ext");

    // ALU vs load response in the same cycle: load first
    push_ld(5'd2, 3'b010, 2'd0);
    beat(1'b1, 5'd1, 32'hA5A5_0001, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h1122_3344);
    beat(1'b1, 5'd1, 32'hA5A5_0001, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    nop();
    check("conflict_drained", 32'(sb.size()), 32'h0);

    // Fill the FIFO, refused push, then push+pop at full
    for (int i = 0; i < LD_DEPTH; i++) push_ld(5'(10 + i), 3'b010, 2'd0);
    check_state("full");
    push_ld(5'd20, 3'b010, 2'd0);
    beat(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 3'b000, 2'd0, 1'b1, 32'h0000_1000);
    check_state("full_pushpop");
    for (int i = 0; i < LD_DEPTH; i++) rsp(32'h0101_0000 + 32'(i));
    nop();
    check_state("drained");

    // Errors: orphan response, x0 load, unsupported funct3
    rsp(32'h5555_5555);
    check_state("orphan");
    do_reset();
    push_ld(5'd0, 3'b010, 2'd0);
    check_state("x0_pushed");
    rsp(32'h7777_7777);
    check("x0_wr_en", {31'h0, bus.rd0_wr_en}, 32'h0);
    check_state("x0_popped");
    push_ld(5'd7, 3'b011, 2'd0); rsp(32'h1234_5678);
    check_state("bad_f3");

    // Clock enable low freezes everything
    do_reset();
    push_ld(5'd9, 3'b010, 2'd0); push_ld(5'd10, 3'b010, 2'd0);
    clk_en = 1'b0;
    bus.ld_req_valid = 1'b1; bus.ld_rd_addr = 5'd11; bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd12;
    #2;
    check("cken_alu_ready", {31'h0, bus.alu_ready}, 32'h0);
    check("cken_ld_ready", {31'h0, bus.ld_req_ready}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    clk_en = 1'b1;
    check("cken_wr_en", {31'h0, bus.rd0_wr_en}, 32'h0);
    check_state("cken");

    // Reset with two loads pending
    do_reset();
    check("midrst_wr_en", {31'h0, bus.rd0_wr_en}, 32'h0);
    check_state("midrst");
    rsp(32'h0);
    check_state("midrst_orphan");

    nop(); nop();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
